// File: rtl/spi_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// spi_arbiter_pkg
// Shared definitions for the SPI master arbiter: default geometry, the
// arbiter state encoding and a helper for index widths.
// ---------------------------------------------------------------------------
package spi_arbiter_pkg;

   localparam int NUM_REQ_DEF  = 4;
   localparam int SIZE_DEF     = 40;
   localparam int CS_WIDTH_DEF = 4;
   localparam int TIMEOUT_DEF  = 1023;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_START = 3'd2,
      ST_BUSY  = 3'd3,
      ST_DONE  = 3'd4
   } arb_state_t;

   // Width needed to hold an index 0..n-1, never less than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// ---------------------------------------------------------------------------
// spi_arbiter_if
// Bundles the requester-side and SPI-master-side signals of the arbiter.
//   slave  : arbiter view (requests + master status in, grants/responses out)
//   master : environment view (requesters and SPI master drive the inputs)
// Requester k owns req_cs_in[k*CS_WIDTH +: CS_WIDTH] and
// req_data_in[k*SIZE +: SIZE].
// ---------------------------------------------------------------------------
interface spi_arbiter_if
   import spi_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int SIZE     = SIZE_DEF,
   parameter int CS_WIDTH = CS_WIDTH_DEF
);
   logic [NUM_REQ-1:0]          req_valid_in;
   logic [NUM_REQ*CS_WIDTH-1:0] req_cs_in;
   logic [NUM_REQ*SIZE-1:0]     req_data_in;
   logic [NUM_REQ-1:0]          r_req_accept_out;
   logic [NUM_REQ-1:0]          r_resp_valid_out;
   logic [SIZE-1:0]             r_resp_data_out;
   logic                        r_resp_err_out;
   logic [SIZE-1:0]             r_spi_data_out;
   logic [CS_WIDTH-1:0]         r_spi_cs_select_out;
   logic                        r_spi_send_enable_out;
   logic [SIZE-1:0]             spi_data_in;
   logic                        spi_ready_in;
   logic                        r_busy_out;

   modport slave (
      input  req_valid_in, req_cs_in, req_data_in, spi_data_in, spi_ready_in,
      output r_req_accept_out, r_resp_valid_out, r_resp_data_out, r_resp_err_out,
             r_spi_data_out, r_spi_cs_select_out, r_spi_send_enable_out, r_busy_out
   );

   modport master (
      output req_valid_in, req_cs_in, req_data_in, spi_data_in, spi_ready_in,
      input  r_req_accept_out, r_resp_valid_out, r_resp_data_out, r_resp_err_out,
             r_spi_data_out, r_spi_cs_select_out, r_spi_send_enable_out, r_busy_out
   );
endinterface

// File: rtl/spi_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: first set bit of i_req searching upward
// from i_ptr with wrap-around. The pointer register lives in the caller.
//   i_req   : request vector
//   i_ptr   : search start index (must be < NUM_REQ)
//   o_grant : one-hot winner (0 when no request)
//   o_idx   : winner index
//   o_any   : at least one request present
// ---------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);
   logic [IDX_W:0]   w_sum;
   logic [IDX_W-1:0] w_cand;
   logic             w_found;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      w_cand  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         // candidate = (ptr + off) mod NUM_REQ without a divider
         w_sum = {1'b0, i_ptr} + (IDX_W+1)'(off);
         if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
         end
         w_cand = w_sum[IDX_W-1:0];
         if (!w_found && i_req[w_cand]) begin
            w_found         = 1'b1;
            o_grant[w_cand] = 1'b1;
            o_idx           = w_cand;
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/spi_arbiter.sv
// ---------------------------------------------------------------------------
// spi_arbiter
// Shares one SPI master between NUM_REQ requesters. Round-robin grant, one
// transfer at a time through the master's send_enable/ready handshake, and
// the received datagram is returned to the granted requester. A transfer
// that spends TIMEOUT cycles in START+BUSY is aborted with an error response.
//   clk_in      : system clock
//   reset_n_in  : asynchronous active-low reset
//   bus         : requester and SPI-master signals (spi_arbiter_if.slave)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a request while the master reports ready
// LOAD  | winner's cs/data presented to master, accept pulse to winner
// START | send_enable high until the master drops ready
// BUSY  | master shifting, waiting for ready to return
// DONE  | response pulse to winner with data captured from the master
// ---------------------------------------------------------------------------
module spi_arbiter
   import spi_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = NUM_REQ_DEF,
   parameter int SIZE     = SIZE_DEF,
   parameter int CS_WIDTH = CS_WIDTH_DEF,
   parameter int TIMEOUT  = TIMEOUT_DEF
) (
   input  logic         clk_in,
   input  logic         reset_n_in,
   spi_arbiter_if.slave bus
);
   localparam int IDX_W = idx_width(NUM_REQ);
   localparam int TO_W  = $clog2(TIMEOUT + 1);

   arb_state_t          r_state;
   arb_state_t          w_state_nxt;
   logic [IDX_W-1:0]    r_ptr;
   logic [NUM_REQ-1:0]  r_grant_oh;
   logic [TO_W-1:0]     r_cnt;
   logic [NUM_REQ-1:0]  r_accept;
   logic [NUM_REQ-1:0]  r_resp_valid;
   logic [SIZE-1:0]     r_resp_data;
   logic                r_resp_err;
   logic [SIZE-1:0]     r_spi_data;
   logic [CS_WIDTH-1:0] r_spi_cs;
   logic                r_send_en;
   logic                r_busy;

   logic [NUM_REQ-1:0]  w_grant;
   logic [IDX_W-1:0]    w_idx;
   logic                w_any;
   logic                w_cnt_tc;
   logic                w_timeout;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_arbiter (
      .i_req   (bus.req_valid_in),
      .i_ptr   (r_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Terminal count: this is the TIMEOUT-th cycle spent in START+BUSY.
   assign w_cnt_tc = (r_cnt == TO_W'(TIMEOUT - 1));

   always_comb begin
      w_state_nxt = r_state;
      w_timeout   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_any && bus.spi_ready_in) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: w_state_nxt = ST_START;
         ST_START: begin
            if (w_cnt_tc) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (!bus.spi_ready_in) begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (w_cnt_tc) begin
               w_timeout   = 1'b1;
               w_state_nxt = ST_IDLE;
            end else if (bus.spi_ready_in) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n_in) begin
      if (!reset_n_in) begin
         r_state      <= ST_IDLE;
         r_ptr        <= '0;
         r_grant_oh   <= '0;
         r_cnt        <= '0;
         r_accept     <= '0;
         r_resp_valid <= '0;
         r_resp_data  <= '0;
         r_resp_err   <= 1'b0;
         r_spi_data   <= '0;
         r_spi_cs     <= '0;
         r_send_en    <= 1'b0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_busy       <= (w_state_nxt != ST_IDLE);
         r_accept     <= '0;
         r_resp_valid <= '0;
         case (r_state)
            ST_IDLE: begin
               // Winner is latched on the way into LOAD so the accept pulse
               // and the master-facing data are both visible during LOAD.
               if (w_state_nxt == ST_LOAD) begin
                  r_accept   <= w_grant;
                  r_grant_oh <= w_grant;
                  r_spi_data <= bus.req_data_in[int'(w_idx)*SIZE +: SIZE];
                  r_spi_cs   <= bus.req_cs_in[int'(w_idx)*CS_WIDTH +: CS_WIDTH];
                  if (w_idx == IDX_W'(NUM_REQ - 1)) r_ptr <= '0;
                  else                              r_ptr <= w_idx + 1'b1;
               end
            end
            ST_LOAD: begin
               r_cnt     <= '0;
               r_send_en <= 1'b1;
            end
            ST_START, ST_BUSY: begin
               if (w_timeout) begin
                  r_send_en    <= 1'b0;
                  r_resp_valid <= r_grant_oh;
                  r_resp_data  <= '0;
                  r_resp_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (w_state_nxt == ST_BUSY) r_send_en <= 1'b0;
                  if (w_state_nxt == ST_DONE) begin
                     r_resp_valid <= r_grant_oh;
                     r_resp_data  <= bus.spi_data_in;
                     r_resp_err   <= 1'b0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.r_req_accept_out      = r_accept;
   assign bus.r_resp_valid_out      = r_resp_valid;
   assign bus.r_resp_data_out       = r_resp_data;
   assign bus.r_resp_err_out        = r_resp_err;
   assign bus.r_spi_data_out        = r_spi_data;
   assign bus.r_spi_cs_select_out   = r_spi_cs;
   assign bus.r_spi_send_enable_out = r_send_en;
   assign bus.r_busy_out            = r_busy;

endmodule

// File: tb/tb_spi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spi_arbiter
// Directed bench for spi_arbiter with a small behavioural SPI master.
// Master modes: 0 = answers send_enable (ready low for m_hold cycles),
// 1 = never drops ready, 2 = passive (ready driven by the main sequence).
// ---------------------------------------------------------------------------
module tb_spi_arbiter;
   localparam int NUM_REQ = 4;
   localparam int SIZE    = 40;
   localparam int CS_W    = 4;
   localparam int TIMEOUT = 1023;

   logic clk_in     = 1'b0;
   logic reset_n_in = 1'b0;

   int n_cmp = 0;
   int n_bad = 0;

   int              m_mode = 0;
   int              m_hold = 8;
   int              m_cnt  = 0;
   logic [SIZE-1:0] m_resp = '0;

   spi_arbiter_if #(.NUM_REQ(NUM_REQ), .SIZE(SIZE), .CS_WIDTH(CS_W)) bus ();

   spi_arbiter #(
      .NUM_REQ  (NUM_REQ),
      .SIZE     (SIZE),
      .CS_WIDTH (CS_W),
      .TIMEOUT  (TIMEOUT)
   ) dut (
      .clk_in     (clk_in),
      .reset_n_in (reset_n_in),
      .bus        (bus)
   );

   always #20 clk_in = ~clk_in;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [NUM_REQ-1:0] onehot(input int k);
      logic [NUM_REQ-1:0] v;
      v    = '0;
      v[k] = 1'b1;
      return v;
   endfunction

   task automatic step();
      @(posedge clk_in);
      #1;
   endtask

   // Behavioural SPI master, acting 2 time units after each rising edge.
   initial begin
      bus.spi_ready_in = 1'b1;
      bus.spi_data_in  = '0;
      forever begin
         @(posedge clk_in);
         #2;
         if (!reset_n_in) begin
            if (m_mode != 2) bus.spi_ready_in = 1'b1;
            m_cnt = 0;
         end else if (m_mode == 0) begin
            if (bus.spi_ready_in && bus.r_spi_send_enable_out) begin
               bus.spi_ready_in = 1'b0;
               m_cnt = m_hold;
            end else if (!bus.spi_ready_in) begin
               m_cnt--;
               if (m_cnt <= 0) begin
                  bus.spi_data_in  = m_resp;
                  bus.spi_ready_in = 1'b1;
               end
            end
         end
      end
   end

   task automatic wait_resp(input int k, input logic [SIZE-1:0] exp_data, input logic exp_err,
                            input string tag, output int lat);
      lat = 0;
      while (lat < 1200 && bus.r_resp_valid_out == '0) begin
         step();
         lat++;
      end
      check_val({tag, "_resp_valid"}, 64'(bus.r_resp_valid_out), 64'(onehot(k)));
      check_val({tag, "_resp_data"},  64'(bus.r_resp_data_out),  64'(exp_data));
      check_val({tag, "_resp_err"},   64'(bus.r_resp_err_out),   64'(exp_err));
   endtask

   task automatic wait_idle(input string tag);
      for (int i = 0; i < 100 && bus.r_busy_out; i++) step();
      check_val({tag, "_idle"}, 64'(bus.r_busy_out), 64'd0);
   endtask

   task automatic do_xfer(input int k, input logic [CS_W-1:0] cs, input logic [SIZE-1:0] d,
                          input logic [SIZE-1:0] resp, input int hold, input string tag);
      int lat;
      m_mode = 0;
      m_hold = hold;
      m_resp = resp;
      bus.req_cs_in[k*CS_W +: CS_W]   = cs;
      bus.req_data_in[k*SIZE +: SIZE] = d;
      bus.req_valid_in[k]             = 1'b1;
      step();
      check_val({tag, "_accept"}, 64'(bus.r_req_accept_out),    64'(onehot(k)));
      check_val({tag, "_cs"},     64'(bus.r_spi_cs_select_out), 64'(cs));
      check_val({tag, "_spidata"},64'(bus.r_spi_data_out),      64'(d));
      bus.req_valid_in[k] = 1'b0;
      wait_resp(k, resp, 1'b0, tag, lat);
      // ready low for hold edges, plus LOAD->START and the DONE capture edge
      check_val({tag, "_latency"}, 64'(lat), 64'(hold + 2));
      step();
      check_val({tag, "_resp_pulse"}, 64'(bus.r_resp_valid_out), 64'd0);
   endtask

   // All requesters held valid; grants must follow start, start+1, ... mod 4.
   task automatic rr_run(input int start, input int n, input string tag);
      int got;
      int exp;
      got    = 0;
      m_mode = 0;
      m_hold = 2;
      m_resp = 40'h11_2233_4455;
      for (int k = 0; k < NUM_REQ; k++) begin
         bus.req_cs_in[k*CS_W +: CS_W]   = CS_W'(k + 4);
         bus.req_data_in[k*SIZE +: SIZE] = SIZE'(k);
      end
      bus.req_valid_in = '1;
      for (int i = 0; i < 400 && got < n; i++) begin
         step();
         if (bus.r_req_accept_out != '0) begin
            exp = (start + got) % NUM_REQ;
            check_val({tag, "_grant"}, 64'(bus.r_req_accept_out),    64'(onehot(exp)));
            check_val({tag, "_cs"},    64'(bus.r_spi_cs_select_out), 64'(exp + 4));
            got++;
            if (got == n) bus.req_valid_in = '0;
         end
      end
      check_val({tag, "_grants"}, 64'(got), 64'(n));
      bus.req_valid_in = '0;
      wait_idle(tag);
   endtask

   task automatic apply_reset();
      reset_n_in = 1'b0;
      step();
      step();
      reset_n_in = 1'b1;
      step();
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_accept"},  64'(bus.r_req_accept_out),      64'd0);
      check_val({tag, "_rvalid"},  64'(bus.r_resp_valid_out),      64'd0);
      check_val({tag, "_rdata"},   64'(bus.r_resp_data_out),       64'd0);
      check_val({tag, "_rerr"},    64'(bus.r_resp_err_out),        64'd0);
      check_val({tag, "_spidata"}, 64'(bus.r_spi_data_out),        64'd0);
      check_val({tag, "_cs"},      64'(bus.r_spi_cs_select_out),   64'd0);
      check_val({tag, "_senden"},  64'(bus.r_spi_send_enable_out), 64'd0);
      check_val({tag, "_busy"},    64'(bus.r_busy_out),            64'd0);
   endtask

   initial begin
      int                 lat;
      logic [NUM_REQ-1:0] acc_a;
      logic [NUM_REQ-1:0] acc_r;

      bus.req_valid_in = '0;
      bus.req_cs_in    = '0;
      bus.req_data_in  = '0;
      repeat (3) step();
      check_all_zero("reset");
      reset_n_in = 1'b1;
      step();

      // single request from requester 1
      do_xfer(1, 4'd3, 40'hA5_1234_5678, 40'h00_DEAD_BEEF, 8, "t1");

      // pointer now 2: all valid -> 2,3,0,1
      rr_run(2, 4, "t2_ptr2");

      // after reset pointer is 0: 0,1,2,3,0
      apply_reset();
      rr_run(0, 5, "t2_rst");

      // master never drops ready -> timeout abort
      m_mode = 1;
      bus.req_cs_in[3*CS_W +: CS_W]   = 4'd9;
      bus.req_data_in[3*SIZE +: SIZE] = 40'hFF_0000_00FF;
      bus.req_valid_in[3]             = 1'b1;
      step();
      check_val("t3_accept", 64'(bus.r_req_accept_out), 64'(onehot(3)));
      bus.req_valid_in[3] = 1'b0;
      wait_resp(3, '0, 1'b1, "t3", lat);
      check_val("t3_latency", 64'(lat), 64'(TIMEOUT + 1));
      check_val("t3_senden",  64'(bus.r_spi_send_enable_out), 64'd0);
      step();
      check_val("t3_busy_next",  64'(bus.r_busy_out),       64'd0);
      check_val("t3_resp_pulse", 64'(bus.r_resp_valid_out), 64'd0);
      m_mode = 0;

      // reset while in BUSY
      m_hold = 20;
      m_resp = 40'h55_5555_5555;
      bus.req_cs_in[0*CS_W +: CS_W]   = 4'd2;
      bus.req_data_in[0*SIZE +: SIZE] = 40'h01_0203_0405;
      bus.req_valid_in[0]             = 1'b1;
      step();
      check_val("t4_accept", 64'(bus.r_req_accept_out), 64'(onehot(0)));
      bus.req_valid_in[0] = 1'b0;
      repeat (4) step();
      check_val("t4_in_busy", 64'(bus.r_busy_out), 64'd1);
      check_val("t4_senden_dropped", 64'(bus.r_spi_send_enable_out), 64'd0);
      reset_n_in = 1'b0;
      #1;
      check_all_zero("t4_rst");
      step();
      step();
      reset_n_in = 1'b1;
      acc_a = '0;
      acc_r = '0;
      repeat (6) begin
         step();
         acc_a |= bus.r_req_accept_out;
         acc_r |= bus.r_resp_valid_out;
      end
      check_val("t4_no_resp",   64'(acc_r), 64'd0);
      check_val("t4_no_accept", 64'(acc_a), 64'd0);
      do_xfer(2, 4'd5, 40'h12_3456_789A, 40'hCA_FE00_0001, 3, "t4_after");

      // master busy in IDLE holds off the grant
      m_mode = 2;
      bus.spi_ready_in = 1'b0;
      bus.req_cs_in[1*CS_W +: CS_W]   = 4'd1;
      bus.req_data_in[1*SIZE +: SIZE] = 40'h77_7777_0001;
      bus.req_valid_in[1]             = 1'b1;
      acc_a = '0;
      repeat (6) begin
         step();
         acc_a |= bus.r_req_accept_out;
      end
      check_val("t5_no_accept", 64'(acc_a), 64'd0);
      bus.spi_ready_in = 1'b1;
      step();
      check_val("t5_accept", 64'(bus.r_req_accept_out), 64'(onehot(1)));
      bus.req_valid_in[1] = 1'b0;
      m_hold = 2;
      m_resp = 40'h0B_0B0B_0B0B;
      m_mode = 0;
      wait_resp(1, 40'h0B_0B0B_0B0B, 1'b0, "t5", lat);
      wait_idle("t5");

      // withdrawn request: no grant and pointer stays at 2
      m_mode = 2;
      bus.spi_ready_in = 1'b0;
      bus.req_valid_in[2] = 1'b1;
      step();
      step();
      bus.req_valid_in[2] = 1'b0;
      step();
      bus.spi_ready_in = 1'b1;
      acc_a = '0;
      repeat (4) begin
         step();
         acc_a |= bus.r_req_accept_out;
      end
      check_val("t6_no_accept", 64'(acc_a), 64'd0);
      m_hold = 2;
      m_resp = 40'h66_0000_0066;
      m_mode = 0;
      bus.req_valid_in = '1;
      step();
      check_val("t6_ptr_kept", 64'(bus.r_req_accept_out), 64'(onehot(2)));
      bus.req_valid_in = '0;
      wait_resp(2, 40'h66_0000_0066, 1'b0, "t6", lat);
      wait_idle("t6");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
